// File: rtl/gbus_pkg.sv
// Shared GBUS write-channel definitions: field widths, broadcast ID,
// buffered write record and packed-address slice helpers.
package gbus_pkg;

   localparam int HEAD_BIAS_W = 2;
   localparam int CORE_ADDR_W = 4;
   localparam int CMEM_ADDR_W = 13;
   localparam int GBUS_DATA_W = 128;
   localparam int GBUS_ADDR_W = HEAD_BIAS_W + CORE_ADDR_W + CMEM_ADDR_W;

   localparam logic [CORE_ADDR_W-1:0] GBUS_BCAST_ID = '1;

   typedef struct packed {
      logic [HEAD_BIAS_W-1:0] bias;
      logic [CMEM_ADDR_W-1:0] cmem_addr;
      logic [GBUS_DATA_W-1:0] data;
   } gbus_wr_t;

   function automatic logic [HEAD_BIAS_W-1:0] gbus_bias(input logic [GBUS_ADDR_W-1:0] addr);
      return addr[GBUS_ADDR_W-1 -: HEAD_BIAS_W];
   endfunction

   function automatic logic [CORE_ADDR_W-1:0] gbus_core(input logic [GBUS_ADDR_W-1:0] addr);
      return addr[CMEM_ADDR_W +: CORE_ADDR_W];
   endfunction

   function automatic logic [CMEM_ADDR_W-1:0] gbus_cmem(input logic [GBUS_ADDR_W-1:0] addr);
      return addr[CMEM_ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/gbus_rx_fifo.sv
// Synchronous FIFO buffering accepted GBUS writes; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module gbus_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage is not reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gbus_cmem_rx.sv
// Core-side GBUS write receiver: filters writes by core ID or broadcast,
// buffers them and issues them to the CMEM write port under grant.
module gbus_cmem_rx
   import gbus_pkg::*;
#(
   parameter int GBUS_DATA_W = gbus_pkg::GBUS_DATA_W,
   parameter int HEAD_BIAS_W = gbus_pkg::HEAD_BIAS_W,
   parameter int CORE_ADDR_W = gbus_pkg::CORE_ADDR_W,
   parameter int CMEM_ADDR_W = gbus_pkg::CMEM_ADDR_W,
   parameter int FIFO_DEPTH  = 4,
   parameter int DROP_CNT_W  = 16
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [CORE_ADDR_W-1:0]                     core_id,
   input  logic [HEAD_BIAS_W+CORE_ADDR_W+CMEM_ADDR_W-1:0] in_gbus_addr,
   input  logic                                       in_gbus_wen,
   input  logic [GBUS_DATA_W-1:0]                     in_gbus_wdata,
   output logic                                       cmem_wen,
   input  logic                                       cmem_wgnt,
   output logic [HEAD_BIAS_W-1:0]                     cmem_wbias,
   output logic [CMEM_ADDR_W-1:0]                     cmem_waddr,
   output logic [GBUS_DATA_W-1:0]                     cmem_wdata,
   output logic [$clog2(FIFO_DEPTH):0]                pending,
   output logic [DROP_CNT_W-1:0]                      drop_cnt,
   output logic                                       ovf_err,
   input  logic                                       stat_clear
);

   localparam int AW = HEAD_BIAS_W + CORE_ADDR_W + CMEM_ADDR_W;
   localparam int EW = HEAD_BIAS_W + CMEM_ADDR_W + GBUS_DATA_W;

   logic [HEAD_BIAS_W-1:0] a_bias;
   logic [CORE_ADDR_W-1:0] a_core;
   logic [CMEM_ADDR_W-1:0] a_cmem;
   logic                   match;
   logic                   pop;
   logic                   drop;
   logic                   full;
   logic                   empty;
   logic [EW-1:0]          head;

   assign a_bias = in_gbus_addr[AW-1 -: HEAD_BIAS_W];
   assign a_core = in_gbus_addr[CMEM_ADDR_W +: CORE_ADDR_W];
   assign a_cmem = in_gbus_addr[CMEM_ADDR_W-1:0];

   assign match = in_gbus_wen & ((a_core == core_id) | (a_core == {CORE_ADDR_W{1'b1}}));
   assign pop   = cmem_wen & cmem_wgnt;
   assign drop  = match & full & ~pop;

   gbus_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (match),
      .pop   (pop),
      .wdata ({a_bias, a_cmem, in_gbus_wdata}),
      .rdata (head),
      .count (pending),
      .full  (full),
      .empty (empty)
   );

   assign cmem_wen = ~empty;
   assign {cmem_wbias, cmem_waddr, cmem_wdata} = empty ? '0 : head;

   // A drop coinciding with stat_clear restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         ovf_err  <= 1'b0;
      end else if (drop) begin
         ovf_err <= 1'b1;
         if (stat_clear)          drop_cnt <= DROP_CNT_W'(1);
         else if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end else if (stat_clear) begin
         drop_cnt <= '0;
         ovf_err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gbus_cmem_rx.sv
// Scoreboard bench for gbus_cmem_rx: an independent model tracks accepted
// writes, drops and status; CMEM handshakes are checked against the queue.
module tb_gbus_cmem_rx;
   import gbus_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [3:0]             core_id = 4'd3;
   logic [18:0]            in_gbus_addr = '0;
   logic                   in_gbus_wen = 1'b0;
   logic [127:0]           in_gbus_wdata = '0;
   logic                   cmem_wen;
   logic                   cmem_wgnt = 1'b1;
   logic [1:0]             cmem_wbias;
   logic [12:0]            cmem_waddr;
   logic [127:0]           cmem_wdata;
   logic [2:0]             pending;
   logic [15:0]            drop_cnt;
   logic                   ovf_err;
   logic                   stat_clear = 1'b0;

   int total = 0;
   int bad   = 0;

   gbus_cmem_rx #(
      .GBUS_DATA_W (128),
      .HEAD_BIAS_W (2),
      .CORE_ADDR_W (4),
      .CMEM_ADDR_W (13),
      .FIFO_DEPTH  (4),
      .DROP_CNT_W  (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .core_id       (core_id),
      .in_gbus_addr  (in_gbus_addr),
      .in_gbus_wen   (in_gbus_wen),
      .in_gbus_wdata (in_gbus_wdata),
      .cmem_wen      (cmem_wen),
      .cmem_wgnt     (cmem_wgnt),
      .cmem_wbias    (cmem_wbias),
      .cmem_waddr    (cmem_waddr),
      .cmem_wdata    (cmem_wdata),
      .pending       (pending),
      .drop_cnt      (drop_cnt),
      .ovf_err       (ovf_err),
      .stat_clear    (stat_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model, sampled mid-cycle while inputs are stable.
   gbus_wr_t   exp_q[$];
   gbus_wr_t   e;
   int         mp = 0;
   logic [15:0] mdrop = '0;
   logic       movf = 1'b0;
   logic       m_pop, m_match, m_push, m_drop;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mp    = 0;
         mdrop = '0;
         movf  = 1'b0;
      end else begin
         check("wen", cmem_wen, mp != 0);
         check("pending", pending, mp);
         check("drop_cnt", drop_cnt, mdrop);
         check("ovf_err", ovf_err, movf);
         if (mp == 0) check("mask", {cmem_wbias, cmem_waddr, cmem_wdata}, '0);
         m_pop = (mp != 0) && cmem_wgnt;
         if (m_pop) begin
            e = exp_q.pop_front();
            check("wbias", cmem_wbias, e.bias);
            check("waddr", cmem_waddr, e.cmem_addr);
            check("wdata", cmem_wdata, e.data);
         end
         m_match = in_gbus_wen && (gbus_core(in_gbus_addr) == core_id || gbus_core(in_gbus_addr) == GBUS_BCAST_ID);
         m_push  = m_match && (mp < 4 || m_pop);
         m_drop  = m_match && !m_push;
         if (m_push) begin
            e.bias      = gbus_bias(in_gbus_addr);
            e.cmem_addr = gbus_cmem(in_gbus_addr);
            e.data      = in_gbus_wdata;
            exp_q.push_back(e);
         end
         mp = mp + int'(m_push) - int'(m_pop);
         if (m_drop) begin
            movf  = 1'b1;
            mdrop = stat_clear ? 16'd1 : (mdrop == 16'hFFFF ? mdrop : mdrop + 16'd1);
         end else if (stat_clear) begin
            movf  = 1'b0;
            mdrop = '0;
         end
      end
   end

   // All drivers start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_gbus_addr  = 19'($urandom());
         in_gbus_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] b, input logic [3:0] c, input logic [12:0] a,
                     input logic [127:0] d, input logic sc);
      in_gbus_wen   = 1'b1;
      in_gbus_addr  = {b, c, a};
      in_gbus_wdata = d;
      stat_clear    = sc;
      @(posedge clk);
      #1;
      in_gbus_wen   = 1'b0;
      stat_clear    = 1'b0;
      in_gbus_addr  = 19'($urandom());
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   logic [127:0] d1;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_pending", pending, 0);
      check("rst_wen", cmem_wen, 0);
      check("rst_drop", drop_cnt, 0);
      rst = 1'b0;
      idle(1);

      // Single matched write, one-cycle latency
      d1 = rnd128();
      wr(2'd1, 4'd3, 13'h0A5, d1, 1'b0);
      check("lat_wen", cmem_wen, 1);
      check("lat_bias", cmem_wbias, 1);
      check("lat_addr", cmem_waddr, 13'h0A5);
      check("lat_data", cmem_wdata, d1);
      idle(1);
      check("lat_done", cmem_wen, 0);

      // Foreign core ignored, broadcast accepted
      wr(2'd0, 4'd5, 13'h111, rnd128(), 1'b0);
      check("foreign_pend", pending, 0);
      wr(2'd2, 4'hF, 13'h010, rnd128(), 1'b0);
      check("bcast_addr", cmem_waddr, 13'h010);
      check("bcast_drop", drop_cnt, 0);
      idle(2);

      // Overflow with grant low, then drain in order
      cmem_wgnt = 1'b0;
      for (int i = 0; i < 6; i++) wr(2'(i), 4'd3, 13'(16'hA0 + i), rnd128(), 1'b0);
      check("ovf_pend", pending, 4);
      check("ovf_drop", drop_cnt, 2);
      check("ovf_err", ovf_err, 1);
      cmem_wgnt = 1'b1;
      idle(5);

      // Lone stat_clear
      stat_clear = 1'b1;
      idle(1);
      stat_clear = 1'b0;
      check("clr_drop", drop_cnt, 0);
      check("clr_ovf", ovf_err, 0);

      // Full with simultaneous pop and push
      cmem_wgnt = 1'b0;
      for (int i = 0; i < 4; i++) wr(2'd0, 4'd3, 13'(16'hB0 + i), rnd128(), 1'b0);
      cmem_wgnt = 1'b1;
      wr(2'd3, 4'd3, 13'h0BF, rnd128(), 1'b0);
      check("fullpop_pend", pending, 4);
      check("fullpop_drop", drop_cnt, 0);
      idle(6);

      // stat_clear coinciding with a drop, then lone clear keeps FIFO
      cmem_wgnt = 1'b0;
      for (int i = 0; i < 4; i++) wr(2'd1, 4'hF, 13'(16'hC0 + i), rnd128(), 1'b0);
      wr(2'd1, 4'd3, 13'h0CF, rnd128(), 1'b1);
      check("clrdrop_cnt", drop_cnt, 1);
      check("clrdrop_ovf", ovf_err, 1);
      stat_clear = 1'b1;
      idle(1);
      stat_clear = 1'b0;
      check("clr2_drop", drop_cnt, 0);
      check("clr2_pend", pending, 4);
      cmem_wgnt = 1'b1;
      idle(6);

      // Asynchronous reset mid-burst
      cmem_wgnt = 1'b0;
      for (int i = 0; i < 3; i++) wr(2'd2, 4'd3, 13'(16'hD0 + i), rnd128(), 1'b0);
      check("pre_rst_pend", pending, 3);
      #2 rst = 1'b1;
      #1;
      check("arst_wen", cmem_wen, 0);
      check("arst_pend", pending, 0);
      check("arst_addr", cmem_waddr, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cmem_wgnt = 1'b1;
      d1 = rnd128();
      wr(2'd3, 4'd3, 13'h1234, d1, 1'b0);
      check("post_rst_wen", cmem_wen, 1);
      check("post_rst_bias", cmem_wbias, 3);
      check("post_rst_addr", cmem_waddr, 13'h1234);
      check("post_rst_data", cmem_wdata, d1);
      idle(3);

      check("drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
